// File: rtl/shift_sequencer.sv
// Command sequencer for the 64-bit load/enable shifter: splits a 0..63 bit shift into load, 8-bit and 1-bit steps.
// Optional performance counters are enabled by defining SHIFT_SEQ_PERF_EN.
module shift_sequencer #(
  parameter int DATA_W = 64,
  parameter int AMT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_dir,
  input  logic [AMT_W-1:0]  req_amt,
  output logic              sh_load,
  output logic              sh_ena,
  output logic [1:0]        sh_amount,
  output logic [DATA_W-1:0] sh_data,
  input  logic [DATA_W-1:0] sh_q,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data
`ifdef SHIFT_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_ops,
  output logic [PERF_W-1:0] perf_busy_cyc
`endif
);

  if (DATA_W != 64) begin : g_bad_data_w
    $error("shift_sequencer: DATA_W must be 64 to match the shifter");
  end
  if (AMT_W != 6) begin : g_bad_amt_w
    $error("shift_sequencer: AMT_W must be 6");
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("shift_sequencer: PERF_W must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STEP8   = 3'd2,
    STEP1   = 3'd3,
    CAPTURE = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [2:0]          n8_q, n8_d;
  logic [2:0]          n1_q, n1_d;
  logic                sh_load_q, sh_load_d;
  logic                sh_ena_q, sh_ena_d;
  logic [1:0]          sh_amount_q, sh_amount_d;
  logic [DATA_W-1:0]   sh_data_q, sh_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;

`ifdef SHIFT_SEQ_PERF_EN
  logic [PERF_W-1:0]   perf_ops_q, perf_ops_d;
  logic [PERF_W-1:0]   perf_busy_q, perf_busy_d;
`endif

  // Shifter pin outputs are registered, so each state's pin values are
  // computed on the transition into that state.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    n8_d         = n8_q;
    n1_d         = n1_q;
    sh_load_d    = 1'b0;
    sh_ena_d     = 1'b0;
    sh_amount_d  = 2'b00;
    sh_data_d    = sh_data_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          sh_data_d = req_data;
          dir_d     = req_dir;
          n8_d      = req_amt[5:3];
          n1_d      = req_amt[2:0];
          sh_load_d = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (n8_q != 3'd0) begin
          state_d     = STEP8;
          sh_ena_d    = 1'b1;
          sh_amount_d = dir_q ? 2'b11 : 2'b01;
        end else if (n1_q != 3'd0) begin
          state_d     = STEP1;
          sh_ena_d    = 1'b1;
          sh_amount_d = dir_q ? 2'b10 : 2'b00;
        end else begin
          state_d = CAPTURE;
        end
      end
      STEP8: begin
        n8_d = n8_q - 3'd1;
        if (n8_q == 3'd1) begin
          if (n1_q != 3'd0) begin
            state_d     = STEP1;
            sh_ena_d    = 1'b1;
            sh_amount_d = dir_q ? 2'b10 : 2'b00;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          sh_ena_d    = 1'b1;
          sh_amount_d = dir_q ? 2'b11 : 2'b01;
        end
      end
      STEP1: begin
        n1_d = n1_q - 3'd1;
        if (n1_q == 3'd1) begin
          state_d = CAPTURE;
        end else begin
          sh_ena_d    = 1'b1;
          sh_amount_d = dir_q ? 2'b10 : 2'b00;
        end
      end
      CAPTURE: begin
        resp_data_d  = sh_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SHIFT_SEQ_PERF_EN
  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_busy_d = perf_busy_q;
    if (state_q == RESP && resp_ready) begin
      perf_ops_d = perf_ops_q + 1'b1;
    end
    if (state_q != IDLE) begin
      perf_busy_d = perf_busy_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      n8_q         <= 3'd0;
      n1_q         <= 3'd0;
      sh_load_q    <= 1'b0;
      sh_ena_q     <= 1'b0;
      sh_amount_q  <= 2'b00;
      sh_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
`ifdef SHIFT_SEQ_PERF_EN
      perf_ops_q   <= '0;
      perf_busy_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      n8_q         <= n8_d;
      n1_q         <= n1_d;
      sh_load_q    <= sh_load_d;
      sh_ena_q     <= sh_ena_d;
      sh_amount_q  <= sh_amount_d;
      sh_data_q    <= sh_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
`ifdef SHIFT_SEQ_PERF_EN
      perf_ops_q   <= perf_ops_d;
      perf_busy_q  <= perf_busy_d;
`endif
    end
  end

  // Ready is a pure decode of the state register, so it never overlaps RESP.
  assign req_ready  = (state_q == IDLE);
  assign sh_load    = sh_load_q;
  assign sh_ena     = sh_ena_q;
  assign sh_amount  = sh_amount_q;
  assign sh_data    = sh_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

`ifdef SHIFT_SEQ_PERF_EN
  assign perf_ops      = perf_ops_q;
  assign perf_busy_cyc = perf_busy_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer, with a behavioural model of the 64-bit step shifter.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_data;
  logic        req_dir;
  logic [5:0]  req_amt;
  logic        sh_load;
  logic        sh_ena;
  logic [1:0]  sh_amount;
  logic [63:0] sh_data;
  logic [63:0] sh_q;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
`ifdef SHIFT_SEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_busy_cyc;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  shift_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_dir    (req_dir),
    .req_amt    (req_amt),
    .sh_load    (sh_load),
    .sh_ena     (sh_ena),
    .sh_amount  (sh_amount),
    .sh_data    (sh_data),
    .sh_q       (sh_q),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
`ifdef SHIFT_SEQ_PERF_EN
    ,
    .perf_ops      (perf_ops),
    .perf_busy_cyc (perf_busy_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the downstream shifter: no reset, load wins over ena.
  logic [63:0] model_q = 64'h0;
  always @(posedge clk) begin
    if (sh_load) model_q <= sh_data;
    else if (sh_ena) begin
      case (sh_amount)
        2'b00: model_q <= model_q << 1;
        2'b01: model_q <= model_q << 8;
        2'b10: model_q <= $signed(model_q) >>> 1;
        default: model_q <= $signed(model_q) >>> 8;
      endcase
    end
  end
  assign sh_q = model_q;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic dir, input logic [5:0] amt);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = data;
    req_dir   = dir;
    req_amt   = amt;
    checkOutput("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [63:0] data, input logic dir,
                       input logic [5:0] amt, input int exp_lat, input int exp_c8,
                       input int exp_c1, input logic [63:0] exp_res);
    int   lat, c8, c1, cbad;
    logic got;
    lat = 0; c8 = 0; c1 = 0; cbad = 0; got = 1'b0;
    applyStimulus(data, dir, amt);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput({name, "_load_pulse"}, {63'd0, sh_load}, 64'd1);
        checkOutput({name, "_sh_data"}, sh_data, data);
      end
      if (sh_ena) begin
        if (sh_amount == (dir ? 2'b11 : 2'b01)) c8++;
        else if (sh_amount == (dir ? 2'b10 : 2'b00)) c1++;
        else cbad++;
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_step8_cycles"}, 64'(c8), 64'(exp_c8));
    checkOutput({name, "_step1_cycles"}, 64'(c1), 64'(exp_c1));
    checkOutput({name, "_bad_amount"}, 64'(cbad), 64'd0);
    checkOutput({name, "_resp_data"}, resp_data, exp_res);
    @(negedge clk);
    checkOutput({name, "_ready_after"}, {63'd0, req_ready}, 64'd1);
    checkOutput({name, "_valid_cleared"}, {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic        saw_resp;
    logic        bp_ok;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_data   = 64'h0;
    req_dir    = 1'b0;
    req_amt    = 6'd0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("reset_sh_pins", {59'd0, sh_load, sh_ena, sh_amount, 1'b0}, 64'd0);
    checkOutput("reset_sh_data", sh_data, 64'd0);
    checkOutput("reset_resp_data", resp_data, 64'd0);

    runOp("left13", 64'h1, 1'b0, 6'd13, 9, 1, 5, 64'h2000);
    runOp("right63", 64'h8000_0000_0000_0000, 1'b1, 6'd63, 17, 7, 7, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("zero", 64'hDEAD_BEEF_0123_4567, 1'b0, 6'd0, 3, 0, 0, 64'hDEAD_BEEF_0123_4567);
    runOp("left4", 64'h0123_4567_89AB_CDEF, 1'b0, 6'd4, 7, 0, 4, 64'h1234_5678_9ABC_DEF0);
    runOp("right9", 64'h8000_0000_0000_0000, 1'b1, 6'd9, 5, 1, 1, 64'hFFC0_0000_0000_0000);
    runOp("left63", 64'h1, 1'b0, 6'd63, 17, 7, 7, 64'h8000_0000_0000_0000);
    runOp("right8_pos", 64'h7000_0000_0000_0000, 1'b1, 6'd8, 4, 1, 0, 64'h0070_0000_0000_0000);

    // Backpressure: result must hold and no new request may be taken.
    resp_ready = 1'b0;
    applyStimulus(64'hFF, 1'b0, 6'd8);
    saw_resp = 1'b0;
    for (int k = 1; k <= 40 && !saw_resp; k++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    checkOutput("bp_resp_seen", {63'd0, saw_resp}, 64'd1);
    req_valid = 1'b1;
    req_data  = 64'h1234;
    req_amt   = 6'd1;
    held      = resp_data;
    checkOutput("bp_resp_data", held, 64'hFF00);
    bp_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== 64'hFF00 || req_ready) bp_ok = 1'b0;
    end
    checkOutput("bp_hold_stable", {63'd0, bp_ok}, 64'd1);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_after", {63'd0, req_ready}, 64'd1);
    checkOutput("bp_valid_cleared", {63'd0, resp_valid}, 64'd0);

    // Reset during STEP1 of an amt=7 request.
    applyStimulus(64'hABCD, 1'b0, 6'd7);
    repeat (3) @(negedge clk);
    checkOutput("rst_in_step1", {63'd0, sh_ena}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid_req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("rst_mid_pins", {59'd0, sh_load, sh_ena, sh_amount, resp_valid}, 64'd0);
    checkOutput("rst_mid_sh_data", sh_data, 64'd0);
    checkOutput("rst_mid_resp_data", resp_data, 64'd0);
    saw_resp = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) saw_resp = 1'b1;
    end
    checkOutput("rst_mid_no_resp", {63'd0, saw_resp}, 64'd0);
    runOp("after_rst", 64'h3, 1'b0, 6'd1, 4, 0, 1, 64'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
